// File: rtl/qtu_node_id_table_update.sv
// qtu_node_id_table_update: neighbor-ID search/append and known-CH bookkeeping per received packet
module qtu_node_id_table_update #(
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = 2048
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fKnownCH,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] mSourceID,
  input  logic [WORD_WIDTH-1:0] mNeighborCount,
  input  logic [WORD_WIDTH-1:0] mKnownCH,
  input  logic [WORD_WIDTH-1:0] mKnownCHCount,
  output logic [WORD_WIDTH-1:0] nodeID,
  output logic [WORD_WIDTH-1:0] neighborCount,
  output logic [WORD_WIDTH-1:0] knownCH,
  output logic [WORD_WIDTH-1:0] knownCHCount,
  output logic                  wr_en,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, SEARCH, COMPARE, APPEND, DONE} state_t;
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] src_q, src_d, cnt_q, cnt_d, idx_q, idx_d, node_q, node_d, ch_q, ch_d, chc_q, chc_d;
  logic ch_hit;
  always_ff @(posedge clk or posedge nrst)
    if (nrst) begin
      state_q <= IDLE;
      src_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      node_q  <= '0;
      ch_q    <= '0;
      chc_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      node_q  <= node_d;
      ch_q    <= ch_d;
      chc_q   <= chc_d;
    end
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    node_d  = node_q;
    ch_d    = ch_q;
    chc_d   = chc_q;
    ch_hit  = fKnownCH != '0 && fKnownCH != mKnownCH;
    case (state_q)
      IDLE: if (en) begin
        src_d   = fSourceID;
        cnt_d   = mNeighborCount;
        idx_d   = '0;
        ch_d    = ch_hit ? fKnownCH : mKnownCH;
        chc_d   = mKnownCHCount + WORD_WIDTH'(ch_hit);
        state_d = (fPacketType == 3'b000 || fPacketType == 3'b111) ? DONE : SEARCH;
      end
      // a full table ends the scan without appending
      SEARCH:  state_d = idx_q != cnt_q ? COMPARE : (cnt_q >= WORD_WIDTH'(MAX_NEIGHBORS)) ? DONE : APPEND;
      COMPARE: begin
        state_d = mSourceID == src_q ? DONE : SEARCH;
        idx_d   = mSourceID == src_q ? idx_q : idx_q + WORD_WIDTH'(1);
      end
      APPEND: begin
        node_d  = src_q;
        cnt_d   = cnt_q + WORD_WIDTH'(1);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign neighborCount = (state_q == SEARCH || state_q == COMPARE) ? idx_q : cnt_q;
  assign nodeID        = state_q == APPEND ? src_q : node_q;
  assign wr_en         = state_q == APPEND;
  assign done          = state_q == DONE;
  assign knownCH       = ch_q;
  assign knownCHCount  = chc_q;
endmodule

// File: tb/tb_qtu_node_id_table_update.sv
// tb_qtu_node_id_table_update: vector table, corner sequences and random checks against a reference model
module tb_qtu_node_id_table_update;
  logic clk = 0, nrst = 1, en = 0;
  logic [15:0] fSourceID = 0, fKnownCH = 0, mSourceID, mNeighborCount = 0, mKnownCH = 0, mKnownCHCount = 0;
  logic [2:0] fPacketType = 0;
  logic [15:0] nodeID, neighborCount, knownCH, knownCHCount;
  logic wr_en, done;
  logic [15:0] mem [0:2047];
  int nvec = 0, nerr = 0;
  typedef struct {
    logic [15:0] cnt, src, fch, mch, mchc;
    logic [2:0]  ptype;
    logic        ewr;
    logic [15:0] ecnt, ech, echc;
    int          elat;
  } vec_t;
  vec_t tbl [7];
  qtu_node_id_table_update dut (
    .clk(clk), .nrst(nrst), .en(en), .fSourceID(fSourceID), .fKnownCH(fKnownCH),
    .fPacketType(fPacketType), .mSourceID(mSourceID), .mNeighborCount(mNeighborCount),
    .mKnownCH(mKnownCH), .mKnownCHCount(mKnownCHCount), .nodeID(nodeID),
    .neighborCount(neighborCount), .knownCH(knownCH), .knownCHCount(knownCHCount),
    .wr_en(wr_en), .done(done)
  );
  always #5 clk = ~clk;
  assign mSourceID = neighborCount < 16'd2048 ? mem[neighborCount[10:0]] : 16'd0;
  always @(posedge clk) if (wr_en && neighborCount < 16'd2048) mem[neighborCount[10:0]] <= nodeID;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int pos = -1;
    bit hit = v.fch != 0 && v.fch != v.mch;
    r.ech  = hit ? v.fch : v.mch;
    r.echc = v.mchc + (hit ? 16'd1 : 16'd0);
    r.ewr  = 0;
    r.ecnt = v.cnt;
    if (v.ptype == 3'd0 || v.ptype == 3'd7) r.elat = 1;
    else begin
      for (int i = 0; i < int'(v.cnt) && i < 2048; i++)
        if (pos < 0 && mem[i] == v.src) pos = i;
      if (pos >= 0) r.elat = 2 * pos + 3;
      else if (v.cnt >= 16'd2048) r.elat = 2 * int'(v.cnt) + 2;
      else begin
        r.elat = 2 * int'(v.cnt) + 3;
        r.ewr  = 1;
        r.ecnt = v.cnt + 16'd1;
      end
    end
    return r;
  endfunction
  task automatic run(input vec_t v, input bit poke);
    int cyc = 0, wrs = 0, bad = 0;
    logic [15:0] widx = 0, wdat = 0;
    @(negedge clk);
    mNeighborCount = v.cnt; fSourceID = v.src; fKnownCH = v.fch; fPacketType = v.ptype;
    mKnownCH = v.mch; mKnownCHCount = v.mchc; en = 1;
    while (1) begin
      @(negedge clk);
      cyc++;
      en = poke && cyc == 2;
      if (poke && cyc == 2) begin fSourceID = v.src + 16'd1; mNeighborCount = 16'd0; end
      if (wr_en) begin wrs++; widx = neighborCount; wdat = nodeID; end
      if (wr_en && done) bad++;
      if (done || cyc > 5000) break;
    end
    chk("latency", cyc, v.elat);
    chk("wr_and_done", bad, 0);
    chk("wr_count", wrs, {31'd0, v.ewr});
    chk("final_count", neighborCount, v.ecnt);
    chk("known_ch", knownCH, v.ech);
    chk("known_ch_count", knownCHCount, v.echc);
    if (v.ewr) begin
      chk("wr_index", widx, v.cnt);
      chk("wr_data", wdat, v.src);
      chk("mem_written", mem[v.cnt[10:0]], v.src);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  initial begin
    vec_t v;
    for (int i = 0; i < 2048; i++) mem[i] = 16'd0;
    mem[1] = 16'd5;
    tbl[0] = '{16'd0, 16'd1,  16'd15, 16'd0,  16'd0,      3'b101, 1'b1, 16'd1, 16'd15, 16'd1, 3};
    tbl[1] = '{16'd2, 16'd17, 16'd15, 16'd15, 16'd1,      3'b101, 1'b1, 16'd3, 16'd15, 16'd1, 7};
    tbl[2] = '{16'd1, 16'd1,  16'd0,  16'd15, 16'd1,      3'b101, 1'b0, 16'd1, 16'd15, 16'd1, 3};
    tbl[3] = '{16'd0, 16'd9,  16'd7,  16'd3,  16'd4,      3'b000, 1'b0, 16'd0, 16'd7,  16'd5, 1};
    tbl[4] = '{16'd2, 16'd1,  16'd0,  16'd4,  16'd9,      3'b111, 1'b0, 16'd2, 16'd4,  16'd9, 1};
    tbl[5] = '{16'd0, 16'd3,  16'd9,  16'd8,  16'hFFFF,   3'b010, 1'b1, 16'd1, 16'd9,  16'd0, 3};
    tbl[6] = '{16'd1, 16'd3,  16'd9,  16'd9,  16'd4,      3'b101, 1'b0, 16'd1, 16'd9,  16'd4, 3};
    repeat (2) @(negedge clk);
    chk("rst_node_id", nodeID, 0);
    chk("rst_count", neighborCount, 0);
    chk("rst_ch", knownCH, 0);
    chk("rst_ch_count", knownCHCount, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    nrst = 0;
    foreach (tbl[i]) run(tbl[i], 0);
    mem[0] = 16'd40; mem[1] = 16'd41; mem[2] = 16'd42;
    v = '{16'd3, 16'd42, 16'd0, 16'd0, 16'd0, 3'b011, 1'b0, 16'd0, 16'd0, 16'd0, 0};
    run(model(v), 1);
    v = '{16'd2, 16'd90, 16'd6, 16'd0, 16'd2, 3'b110, 1'b0, 16'd0, 16'd0, 16'd0, 0};
    run(model(v), 1);
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i + 100);
    v = '{16'd2048, 16'hFFFF, 16'd0, 16'd7, 16'd3, 3'b101, 1'b0, 16'd0, 16'd0, 16'd0, 0};
    v = model(v);
    chk("full_model_count", v.ecnt, 16'd2048);
    run(v, 0);
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd4; mem[3] = 16'd0;
    @(negedge clk);
    mNeighborCount = 16'd3; fSourceID = 16'd77; fKnownCH = 16'd5; mKnownCH = 16'd0;
    mKnownCHCount = 16'd0; fPacketType = 3'b101; en = 1;
    @(negedge clk); en = 0;
    repeat (3) @(negedge clk);
    nrst = 1;
    #1;
    chk("abort_count", neighborCount, 0);
    chk("abort_ch", knownCH, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_done", done, 0);
    repeat (10) @(negedge clk);
    nrst = 0;
    chk("abort_no_write", mem[3], 0);
    for (int n = 0; n < 40; n++) begin
      int c = $urandom_range(0, 10);
      logic [15:0] mch = 16'($urandom_range(0, 3));
      for (int i = 0; i < c; i++) mem[i] = 16'($urandom_range(1, 20));
      v.cnt   = 16'(c);
      v.src   = 16'($urandom_range(1, 20));
      v.mch   = mch;
      v.fch   = ($urandom_range(0, 2) == 0) ? mch : 16'($urandom_range(0, 3));
      v.mchc  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      v.ptype = 3'($urandom);
      run(model(v), $urandom_range(0, 3) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
